adder_bist: RTL and testbench
=============================

# adder_bist

Hardware self-test engine for the `full_adder_4bit` ripple adder and its wider variants. It drives the adder's operand and carry-in inputs and checks its sum and carry-out outputs. After a `start` pulse it sweeps every operand/carry combination exhaustively and compares each result against an internal reference sum. It reports a pass/fail flag, an error count and the first failing vector, which lets adder macros be checked on silicon or FPGA without a simulator testbench.

## Interface
- `WIDTH`, default 4: operand width of the adder under test.
- `SETTLE`, default 1: wait cycles between driving a vector and sampling the result; must be ≥1.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: begin a sweep; sampled only in IDLE and DONE.
- `a_o` output WIDTH: operand A to the adder.
- `b_o` output WIDTH: operand B to the adder.
- `cin_o` output 1: carry-in to the adder.
- `s_i` input WIDTH: sum from the adder.
- `cout_i` input 1: carry-out from the adder.
- `busy` output 1: sweep in progress.
- `done` output 1: sweep complete; results are valid.
- `pass` output 1: high with `done` when zero mismatches occurred.
- `err_count` output 2*WIDTH+2: number of mismatching vectors; cannot overflow.
- `fail_valid` output 1: a first failure has been captured.
- `fail_a`, `fail_b` output WIDTH each: operands of the first failing vector.
- `fail_cin` output 1: carry-in of the first failing vector.
- `fail_sum` output WIDTH+1: observed `{cout_i, s_i}` at the first failure.

## Operation
- Vector counter `vec` is 2*WIDTH+1 bits wide and holds `{cin, b, a}`, with `a` in the LSBs. It sweeps from 0 to all-ones, giving N = 2^(2*WIDTH+1) vectors (512 at WIDTH=4).
- States are IDLE, DRIVE, WAIT, CHECK and DONE.
- IDLE: when `start`=1, clear `vec`, `err_count`, `fail_valid`, `fail_*` and `pass`, then go to DRIVE.
- DRIVE: register `a_o`, `b_o` and `cin_o` from `vec`, load the wait counter with SETTLE, then go to WAIT.
- WAIT: decrement the wait counter each cycle and go to CHECK after SETTLE cycles.
- CHECK: compute expected = `a_o + b_o + cin_o` at WIDTH+1 bits, zero-extended.
  - Mismatch against `{cout_i, s_i}`: increment `err_count`.
  - If also `fail_valid`=0: capture `fail_a`, `fail_b`, `fail_cin` and `fail_sum`, and set `fail_valid`.
  - If `vec` is all-ones: go to DONE.
  - Otherwise increment `vec` and go to DRIVE.
- DONE: `done`=1 and `pass`=(`err_count`==0). All results and `a_o`/`b_o`/`cin_o` hold. `start`=1 clears the results and goes to DRIVE, performing a full restart.
- `busy` is 1 in DRIVE, WAIT and CHECK, and 0 in IDLE and DONE. `start` is ignored while `busy`=1.
- Reset values: all outputs are 0, including `a_o`, `b_o`, `cin_o`, `busy`, `done`, `pass`, `err_count`, `fail_*` and `fail_valid`. The state is IDLE.
- Reset mid-sweep: all outputs go to their reset values immediately and asynchronously. The state becomes IDLE with no partial results retained.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Each vector takes SETTLE+2 cycles: 1 DRIVE, SETTLE WAIT, 1 CHECK.
- Call the edge that samples `start` in IDLE edge 0.
  - `busy` is visible after edge 0.
  - The first vector is driven after edge 1.
  - `done` and `pass` rise and `busy` falls after edge N*(SETTLE+2). That is edge 1536 at WIDTH=4, SETTLE=1.
- The adder sees stable inputs for SETTLE+1 cycles before sampling, so the combinational adder path must close within SETTLE+1 clock periods.
- `err_count` and `fail_*` update on the CHECK edge of the failing vector. They are visible one cycle before the next DRIVE.
- `start` sampled in DONE: `done` and `pass` drop after that edge and `busy` rises on the same edge.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `start`=1. All outputs read 0. Release with `start`=0 for 10 cycles: the block stays IDLE and `busy`=0.
- Golden adder, WIDTH=4, SETTLE=1: pulse `start` for 1 cycle. `busy`=1 after edge 0, and `done`=1 with `pass`=1 after edge 1536. `err_count`=0, `fail_valid`=0, and final `a_o`=F, `b_o`=F, `cin_o`=1.
- Adder with S[0] stuck-at-0: `err_count`=256 and `pass`=0. First failure is `fail_a`=1, `fail_b`=0, `fail_cin`=0, `fail_sum`=0x00.
- Adder with `cout` inverted: `err_count`=512. First failure is a=0, b=0, cin=0 with `fail_sum`=0x10.
- Reset mid-sweep: drop `rst_n` at edge 700. `busy` and `err_count` go to 0 immediately. A restart then completes at 1536 edges with `pass`=1.
- `start` re-pulsed at edge 100 while busy: no effect, and `done` still arrives at edge 1536. `start` in DONE: `done`=0 the next cycle, `err_count` is cleared and a full sweep repeats.

Source files
------------

// File: rtl/adder_bist_if.sv
// Adder-under-test bus: operands and carry-in out, sum and carry-out back.
// The BIST engine is the master; the adder macro is the slave.
interface adder_bist_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a_o;
    logic [WIDTH-1:0] b_o;
    logic             cin_o;
    logic [WIDTH-1:0] s_i;
    logic             cout_i;

    modport master (
        output a_o, b_o, cin_o,
        input  s_i, cout_i
    );

    modport slave (
        input  a_o, b_o, cin_o,
        output s_i, cout_i
    );
endinterface

// File: rtl/adder_bist.sv
// Exhaustive self-test engine for ripple adders: sweeps every {cin,b,a},
// compares {cout,s} with a reference sum, reports count and first failure.
module adder_bist #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    adder_bist_if.master         bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic                 fail_valid,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b,
    output logic                 fail_cin,
    output logic [WIDTH:0]       fail_sum
);
    localparam int VW = 2*WIDTH + 1;
    localparam int EW = 2*WIDTH + 2;
    localparam int WW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [VW-1:0]   vec;
    logic [WW-1:0]   wcnt;
    logic [WIDTH:0]  exp_sum;
    logic [WIDTH:0]  got_sum;
    logic            mismatch;
    logic [EW-1:0]   err_inc;

    // Reference is taken from the registered operands the adder actually sees
    assign exp_sum  = {1'b0, bus.a_o} + {1'b0, bus.b_o}
                    + {{WIDTH{1'b0}}, bus.cin_o};
    assign got_sum  = {bus.cout_i, bus.s_i};
    assign mismatch = (exp_sum != got_sum);
    assign err_inc  = err_count + {{(EW-1){1'b0}}, mismatch};

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start) state_d = S_DRIVE;
            S_DONE:  if (start) state_d = S_DRIVE;
            S_DRIVE: state_d = S_WAIT;
            S_WAIT:  if (wcnt == WW'(1)) state_d = S_CHECK;
            S_CHECK: state_d = (&vec) ? S_DONE : S_DRIVE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            vec        <= '0;
            wcnt       <= '0;
            bus.a_o    <= '0;
            bus.b_o    <= '0;
            bus.cin_o  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
            fail_sum   <= '0;
        end else begin
            state <= state_d;
            busy  <= (state_d == S_DRIVE) || (state_d == S_WAIT)
                  || (state_d == S_CHECK);
            done  <= (state_d == S_DONE);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        vec        <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_cin   <= 1'b0;
                        fail_sum   <= '0;
                        pass       <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    bus.a_o   <= vec[WIDTH-1:0];
                    bus.b_o   <= vec[2*WIDTH-1:WIDTH];
                    bus.cin_o <= vec[2*WIDTH];
                    wcnt      <= WW'(SETTLE);
                end
                S_WAIT: begin
                    wcnt <= wcnt - WW'(1);
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_inc;
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_a     <= bus.a_o;
                            fail_b     <= bus.b_o;
                            fail_cin   <= bus.cin_o;
                            fail_sum   <= got_sum;
                        end
                    end
                    if (&vec) pass <= (err_inc == '0);
                    else      vec  <= vec + VW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: behavioural adder with selectable faults,
// table-driven sweeps checked through a result scoreboard.
module tb_adder_bist;
    localparam int W      = 4;
    localparam int SETTLE = 1;
    localparam int N      = 1 << (2*W + 1);
    localparam int EDGES  = N * (SETTLE + 2);
    localparam int LIMIT  = EDGES + 200;

    typedef struct {
        int mode;
        int err;
        int pass;
        int fv;
        int fa;
        int fb;
        int fc;
        int fs;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, pass, fail_valid, fail_cin;
    logic [2*W+1:0] err_count;
    logic [W-1:0] fail_a, fail_b;
    logic [W:0] fail_sum;

    int mode = 0;
    int checks = 0;
    int failures = 0;
    res_t sb[$];
    res_t tbl[4];

    adder_bist_if #(.WIDTH(W)) bus ();

    adder_bist #(.WIDTH(W), .SETTLE(SETTLE)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .bus(bus),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .fail_valid(fail_valid),
        .fail_a(fail_a),
        .fail_b(fail_b),
        .fail_cin(fail_cin),
        .fail_sum(fail_sum)
    );

    always #5 clk = ~clk;

    // Adder under test: mode 1 = S[0] stuck-at-0, mode 2 = cout inverted
    logic [W:0] sum;
    always_comb begin
        sum = {1'b0, bus.a_o} + {1'b0, bus.b_o} + {{W{1'b0}}, bus.cin_o};
        if (mode == 1) sum[0] = 1'b0;
        if (mode == 2) sum[W] = ~sum[W];
    end
    assign bus.s_i    = sum[W-1:0];
    assign bus.cout_i = sum[W];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse start, then count edges until done; optional re-pulse while busy
    task automatic sweep(input int md, input int pulse_at, output int edges);
        mode = md;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_edge0", busy, 1);
        chk("done_drop_edge0", done, 0);
        chk("err_cleared_edge0", err_count, 0);
        edges = 0;
        while (!done && edges < LIMIT) begin
            @(posedge clk);
            edges++;
            #1;
            start = (edges == pulse_at);
        end
        start = 1'b0;
        if (edges >= LIMIT) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int e;
        res_t r;
        tbl[0] = '{mode: 0, err: 0,   pass: 1, fv: 0, fa: 0, fb: 0, fc: 0, fs: 0};
        tbl[1] = '{mode: 1, err: 256, pass: 0, fv: 1, fa: 1, fb: 0, fc: 0, fs: 0};
        tbl[2] = '{mode: 2, err: 512, pass: 0, fv: 1, fa: 0, fb: 0, fc: 0, fs: 16};
        tbl[3] = '{mode: 0, err: 0,   pass: 1, fv: 0, fa: 0, fb: 0, fc: 0, fs: 0};

        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_fv", fail_valid, 0);
        chk("rst_fsum", fail_sum, 0);
        chk("rst_ops", {bus.cin_o, bus.b_o, bus.a_o}, 0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);

        for (int i = 0; i < 4; i++) begin
            sb.push_back(tbl[i]);
            sweep(tbl[i].mode, (i == 0) ? 100 : -1, e);
            chk("done_edge", e, EDGES);
            chk("busy_at_done", busy, 0);
            if (sb.size() == 0) begin
                chk("sb_empty", 0, 1);
            end else begin
                r = sb.pop_front();
                chk("err_count", err_count, r.err);
                chk("pass", pass, r.pass);
                chk("fail_valid", fail_valid, r.fv);
                chk("fail_a", fail_a, r.fa);
                chk("fail_b", fail_b, r.fb);
                chk("fail_cin", fail_cin, r.fc);
                chk("fail_sum", fail_sum, r.fs);
            end
            chk("final_a", bus.a_o, 15);
            chk("final_b", bus.b_o, 15);
            chk("final_cin", bus.cin_o, 1);
        end

        // Reset mid-sweep with a faulty adder, then clean restart
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (700) @(posedge clk);
        #1;
        chk("mid_err_nonzero", (err_count != 0), 1);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_err", err_count, 0);
        chk("async_fv", fail_valid, 0);
        chk("async_ops", {bus.cin_o, bus.b_o, bus.a_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(0, -1, e);
        chk("restart_edge", e, EDGES);
        chk("restart_pass", pass, 1);
        chk("restart_err", err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
